// File: rtl/core_pkg.sv
// Shared encodings for the core scheduler, PC units, fetcher and LSU.
package core_pkg;

    localparam int unsigned PcWidth = 8;

    typedef enum logic [2:0] {
        StIdle    = 3'b000,
        StFetch   = 3'b001,
        StDecode  = 3'b010,
        StRequest = 3'b011,
        StWait    = 3'b100,
        StExecute = 3'b101,
        StUpdate  = 3'b110,
        StDone    = 3'b111
    } core_state_e;

    localparam logic [2:0] FetcherFetched = 3'b010;
    localparam logic [1:0] LsuRequesting  = 2'b01;
    localparam logic [1:0] LsuWaiting     = 2'b10;

endpackage

// File: rtl/pc_converge.sv
// Picks the committed PC from the lowest enabled lane and flags lanes that disagree.
module pc_converge
    import core_pkg::*;
#(
    parameter int unsigned Lanes = 4
) (
    input  logic [PcWidth*Lanes-1:0] next_pc_i,
    input  logic [Lanes-1:0]         lane_en_i,
    input  logic [PcWidth-1:0]       current_pc_i,
    output logic [PcWidth-1:0]       selected_pc_o,
    output logic                     mismatch_o
);

    always_comb begin
        // No enabled lanes: fall through to the sequential PC.
        selected_pc_o = current_pc_i + PcWidth'(1);
        for (int i = int'(Lanes) - 1; i >= 0; i--) begin
            if (lane_en_i[i]) begin
                selected_pc_o = next_pc_i[PcWidth*i +: PcWidth];
            end
        end

        mismatch_o = 1'b0;
        for (int i = 0; i < int'(Lanes); i++) begin
            if (lane_en_i[i] && (next_pc_i[PcWidth*i +: PcWidth] != selected_pc_o)) begin
                mismatch_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: FETCH..UPDATE loop, LSU wait reduction, PC commit,
// sticky done/diverged flags.
module core_scheduler
    import core_pkg::*;
#(
    parameter int unsigned ThreadsPerBlock = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               start_i,
    input  logic [$clog2(ThreadsPerBlock):0]   thread_count_i,
    input  logic                               decoded_mem_read_enable_i,
    input  logic                               decoded_mem_write_enable_i,
    input  logic                               decoded_ret_i,
    input  logic [2:0]                         fetcher_state_i,
    input  logic [2*ThreadsPerBlock-1:0]       lsu_state_i,
    input  logic [PcWidth*ThreadsPerBlock-1:0] next_pc_i,
    output logic [PcWidth-1:0]                 current_pc_o,
    output logic [2:0]                         core_state_o,
    output logic                               done_o,
    output logic                               diverged_o
);

    core_state_e                state_q, state_d;
    logic [PcWidth-1:0]         pc_q, pc_d;
    logic                       done_q, done_d;
    logic                       div_q, div_d;
    logic [ThreadsPerBlock-1:0] lane_en;
    logic                       lsu_busy;
    logic [PcWidth-1:0]         selected_pc;
    logic                       mismatch;
    logic                       unused_decoded;

    // Memory-op decode is informational; WAIT exit depends only on LSU state.
    assign unused_decoded = decoded_mem_read_enable_i ^ decoded_mem_write_enable_i;

    always_comb begin
        lane_en  = '0;
        lsu_busy = 1'b0;
        for (int i = 0; i < int'(ThreadsPerBlock); i++) begin
            lane_en[i] = (i < int'(thread_count_i));
            if (lane_en[i] && ((lsu_state_i[2*i +: 2] == LsuRequesting) ||
                               (lsu_state_i[2*i +: 2] == LsuWaiting))) begin
                lsu_busy = 1'b1;
            end
        end
    end

    pc_converge #(
        .Lanes(ThreadsPerBlock)
    ) u_pc_converge (
        .next_pc_i    (next_pc_i),
        .lane_en_i    (lane_en),
        .current_pc_i (pc_q),
        .selected_pc_o(selected_pc),
        .mismatch_o   (mismatch)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        div_d   = div_q;
        unique case (state_q)
            StIdle:    if (start_i) state_d = StFetch;
            StFetch:   if (fetcher_state_i == FetcherFetched) state_d = StDecode;
            StDecode:  state_d = StRequest;
            StRequest: state_d = StWait;
            StWait:    if (!lsu_busy) state_d = StExecute;
            StExecute: state_d = StUpdate;
            StUpdate: begin
                if (decoded_ret_i) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d = StFetch;
                    pc_d    = selected_pc;
                    div_d   = div_q | mismatch;
                end
            end
            StDone:    state_d = StDone;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            pc_q    <= '0;
            done_q  <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            div_q   <= div_d;
        end
    end

    assign current_pc_o = pc_q;
    assign core_state_o = state_q;
    assign done_o       = done_q;
    assign diverged_o   = div_q;

endmodule

// File: doc/core_scheduler.md
# core_scheduler

Per-core control FSM that sequences every instruction through FETCH → DECODE → REQUEST → WAIT → EXECUTE → UPDATE. It broadcasts `core_state` and `current_pc` to the per-thread PC units. In UPDATE it collects their `next_pc` values and commits the converged PC. It consumes the per-thread PC units' outputs, detects branch divergence, and raises `done` on RET.

## Interface
- `THREADS_PER_BLOCK`, default 4: number of thread lanes (PC units) in the core.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin executing the block from PC 0. Honoured only in IDLE.
- `thread_count` in $clog2(THREADS_PER_BLOCK)+1: number of active lanes. Lane i is enabled iff i < thread_count.
- `decoded_mem_read_enable` in 1: current instruction is LDR.
- `decoded_mem_write_enable` in 1: current instruction is STR.
- `decoded_ret` in 1: current instruction is RET.
- `fetcher_state` in 3: fetcher FSM state. 3'b010 = FETCHED.
- `lsu_state` in 2×THREADS_PER_BLOCK: per-lane LSU state, packed with lane i at [2i+1:2i]. 2'b01 = REQUESTING, 2'b10 = WAITING.
- `next_pc` in 8×THREADS_PER_BLOCK: per-lane next PC, packed with lane i at [8i+7:8i].
- `current_pc` out 8: PC of the instruction in flight.
- `core_state` out 3: current state.
- `done` out 1: block finished. Sticky until reset.
- `diverged` out 1: sticky flag. Set when enabled lanes disagreed on `next_pc` at a commit.

## Operation
- State encodings: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- Transitions:
  - IDLE: `start` → FETCH. Otherwise stay.
  - FETCH: `fetcher_state == 3'b010` → DECODE. Otherwise stay.
  - DECODE → REQUEST unconditionally.
  - REQUEST → WAIT unconditionally.
  - WAIT: stay while any enabled lane has `lsu_state` of 01 or 10. Otherwise → EXECUTE. Disabled lanes are ignored.
  - EXECUTE → UPDATE unconditionally.
  - UPDATE: if `decoded_ret`, → DONE and set `done`, with `current_pc` unchanged. Otherwise commit the selected PC to `current_pc` and → FETCH.
  - DONE: hold until reset. `start` is ignored.
- PC selection:
  - Selected PC is `next_pc` of the lowest-index enabled lane.
  - If any other enabled lane's `next_pc` differs from the selected value, set `diverged` at the same commit.
  - With thread_count = 0, the selected PC is `current_pc + 1` mod 256, and `diverged` is not set.
- Wrap: no arithmetic is applied to the committed value. A PC unit's 255 → 0 wrap is passed through as-is.
- `decoded_mem_*` inputs are informational only. WAIT exit depends solely on `lsu_state`.

## Timing
- Reset values: `core_state` = IDLE, `current_pc` = 0, `done` = 0, `diverged` = 0.
- Reset takes effect on the next edge from any state, including mid-WAIT and DONE. Reset has priority over all transitions.
- All outputs are registered. `core_state` changes one cycle after the qualifying condition is sampled.
- Minimum instruction length is 6 cycles: FETCH exits on its first cycle, WAIT exits on its first cycle.
- PC units write `next_pc` at the EXECUTE edge. The scheduler samples `next_pc` at the UPDATE edge, so `next_pc` is stable for a full cycle before sampling.
- `current_pc` updates on the UPDATE → FETCH edge. It is stable from FETCH through UPDATE.
- `done` rises on the same edge that `core_state` becomes DONE.
- `start` held high across instructions has no effect outside IDLE.

## Structure
- Shared package `core_pkg`:
  - core-state localparams (IDLE … DONE)
  - fetcher FETCHED code
  - LSU REQUESTING/WAITING codes
  - PC width 8
- These encodings are also used by the PC unit, fetcher, and LSU.
- One sub-module, `pc_converge`, is combinational:
  - inputs: `next_pc` vector, enable mask, `current_pc`
  - outputs: `selected_pc`, `mismatch`
- The FSM, WAIT reduction and sticky flags live in `core_scheduler`.

## Test plan
- Reset then `start` pulse; fetcher reports FETCHED after 3 cycles; lanes report `next_pc` = 1; no LSU activity → states IDLE, FETCH×4, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, FETCH; `current_pc` = 1; `diverged` = 0.
- thread_count = 2, lane 1 `lsu_state` = 10 for 5 cycles while lanes 2–3 sit at 10 permanently → WAIT lasts exactly 5 cycles then EXECUTE.
- Lanes 0–3 report `next_pc` 0x20, 0x20, 0x05, 0x20 with thread_count = 4 → `current_pc` = 0x20, `diverged` = 1. Same vector with thread_count = 2 → `current_pc` = 0x20, `diverged` = 0.
- thread_count = 0 with `current_pc` = 0xFF at UPDATE → `current_pc` = 0x00.
- `decoded_ret` in UPDATE → DONE; `done` = 1; `current_pc` unchanged; subsequent `start` pulses ignored; reset → IDLE with all outputs 0.
- Reset asserted during WAIT with `lsu_state` busy → next cycle `core_state` = IDLE and `current_pc` = 0; a new `start` restarts from PC 0.
